// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame controller.
// Strips preamble/SFD, delays payload by one byte so the final byte can be
// flagged with tlast/tuser, checks frame length and receive errors, and keeps
// saturating good/bad frame counters.
module gmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    input  logic        cfg_enable,
    output logic        m_tvalid,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        busy,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'd2047;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  hold_r;
    logic        hold_valid_r;
    logic [2:0]  pcnt_r;
    logic [10:0] len_r;
    logic        err_r;

    logic        emit_s;
    logic        emit_last_s;
    logic        frame_bad_s;
    logic        inc_good_s;
    logic        inc_bad_s;
    logic        pre_start_s;
    logic        pre_inc_s;
    logic        sfd_s;
    logic        data_byte_s;
    logic        frame_end_s;

    // Saturating 16-bit increment used by both frame counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    assign frame_bad_s = err_r | (len_r < MIN_L) | (len_r > MAX_L);

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s     = state_r;
        emit_s      = 1'b0;
        emit_last_s = 1'b0;
        inc_good_s  = 1'b0;
        inc_bad_s   = 1'b0;
        pre_start_s = 1'b0;
        pre_inc_s   = 1'b0;
        sfd_s       = 1'b0;
        data_byte_s = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (cfg_enable && (gmii_rxd == 8'h55)) begin
                        state_s     = PREAMBLE;
                        pre_start_s = 1'b1;
                    end else begin
                        state_s   = DROP;
                        inc_bad_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PREAMBLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55) begin
                        pre_inc_s = 1'b1;
                    end else if (gmii_rxd == 8'hD5) begin
                        state_s = DATA;
                        sfd_s   = 1'b1;
                    end else begin
                        state_s   = DROP;
                        inc_bad_s = 1'b1;
                    end
                end else begin
                    state_s   = IDLE;
                    inc_bad_s = 1'b1;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    data_byte_s = 1'b1;
                    emit_s      = hold_valid_r;
                end else begin
                    state_s     = IDLE;
                    frame_end_s = 1'b1;
                    if (hold_valid_r) begin
                        emit_s      = 1'b1;
                        emit_last_s = 1'b1;
                        if (frame_bad_s) begin
                            inc_bad_s = 1'b1;
                        end else begin
                            inc_good_s = 1'b1;
                        end
                    end else begin
                        inc_bad_s = 1'b1;
                    end
                end
            end
            DROP: begin
                if (gmii_rx_dv) begin
                    state_s = DROP;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
        end
    end

    // Frame tracking: preamble count, hold byte, length and sticky error.
    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            pcnt_r       <= 3'd0;
            hold_r       <= 8'd0;
            hold_valid_r <= 1'b0;
            len_r        <= 11'd0;
            err_r        <= 1'b0;
        end else begin
            if (pre_start_s) begin
                pcnt_r <= 3'd1;
            end else if (pre_inc_s && (pcnt_r != 3'd7)) begin
                pcnt_r <= pcnt_r + 3'd1;
            end else begin
                pcnt_r <= pcnt_r;
            end
            if (sfd_s) begin
                hold_valid_r <= 1'b0;
                len_r        <= 11'd0;
                err_r        <= 1'b0;
            end else if (data_byte_s) begin
                hold_r       <= gmii_rxd;
                hold_valid_r <= 1'b1;
                len_r        <= (len_r == LEN_SAT) ? len_r : (len_r + 11'd1);
                err_r        <= err_r | gmii_rx_er;
            end else if (frame_end_s) begin
                hold_valid_r <= 1'b0;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
        end
    end

    // Registered payload stream; tvalid/tlast/tuser are single-cycle pulses.
    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 8'd0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else begin
            m_tvalid <= emit_s;
            m_tlast  <= emit_last_s;
            m_tuser  <= emit_last_s & frame_bad_s;
            if (emit_s) begin
                m_tdata <= hold_r;
            end else begin
                m_tdata <= m_tdata;
            end
        end
    end

    // Saturating good/bad frame statistics.
    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            stat_good <= 16'd0;
            stat_bad  <= 16'd0;
        end else begin
            if (inc_good_s) begin
                stat_good <= sat_inc16(stat_good);
            end else begin
                stat_good <= stat_good;
            end
            if (inc_bad_s) begin
                stat_bad <= sat_inc16(stat_bad);
            end else begin
                stat_bad <= stat_bad;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Self-checking bench for gmii_rx_frame_ctrl: table of whole-frame vectors
// plus hand-written sequences for drop, back-to-back, cfg_enable and reset.
module tb_gmii_rx_frame_ctrl;

    logic        gmii_rx_clk = 1'b0;
    logic        rst_n;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        cfg_enable;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;
    logic [15:0] stat_good;
    logic [15:0] stat_bad;

    int checks   = 0;
    int failures = 0;

    // Output monitor state
    int out_cnt, frame_idx, data_err, last_cnt, last_tuser, last_pos, stray;
    int exp_good, exp_bad;

    typedef struct {
        int npre;
        int len;
        int er_idx;
        bit er_pre;
        int exp_n;
        int exp_last;
        int exp_tuser;
        int dgood;
        int dbad;
    } vec_t;

    vec_t vecs[9];

    gmii_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .gmii_rx_clk (gmii_rx_clk),
        .rst_n       (rst_n),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_rxd    (gmii_rxd),
        .cfg_enable  (cfg_enable),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .busy        (busy),
        .stat_good   (stat_good),
        .stat_bad    (stat_bad)
    );

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge gmii_rx_clk) begin
        if (m_tlast && !m_tvalid) stray = stray + 1;
        if (m_tvalid) begin
            if (m_tdata !== 8'(frame_idx)) data_err = data_err + 1;
            out_cnt   = out_cnt + 1;
            frame_idx = frame_idx + 1;
            if (m_tlast) begin
                last_cnt   = last_cnt + 1;
                last_tuser = int'(m_tuser);
                last_pos   = frame_idx;
                frame_idx  = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit dv, input bit er, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        @(posedge gmii_rx_clk);
        #1;
    endtask

    task automatic clear_mon();
        out_cnt = 0; frame_idx = 0; data_err = 0; last_cnt = 0;
        last_tuser = -1; last_pos = -1; stray = 0;
    endtask

    task automatic send_frame(input int npre, input int len, input int er_idx,
                              input bit er_pre, input int ifg);
        for (int i = 0; i < npre; i++) drive(1'b1, er_pre, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < len; i++) drive(1'b1, (i == er_idx), 8'(i));
        for (int i = 0; i < ifg; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        //            npre len  er  erp  n    last tuser dg db
        vecs[0] = '{7,  64,   -1, 0, 64,   1,   0,   1, 0};
        vecs[1] = '{7,  64,   10, 0, 64,   1,   1,   0, 1};
        vecs[2] = '{7,  63,   -1, 0, 63,   1,   1,   0, 1};
        vecs[3] = '{7,  1519, -1, 0, 1519, 1,   1,   0, 1};
        vecs[4] = '{7,  1518, -1, 0, 1518, 1,   0,   1, 0};
        vecs[5] = '{1,  1,    -1, 0, 1,    1,   1,   0, 1};
        vecs[6] = '{7,  0,    -1, 0, 0,    0,   0,   0, 1};
        vecs[7] = '{10, 64,   -1, 1, 64,   1,   0,   1, 0};
        vecs[8] = '{7,  64,   63, 0, 64,   1,   1,   0, 1};

        clear_mon();
        rst_n = 1'b0; cfg_enable = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_tdata", int'(m_tdata), 0);
        check("rst_tlast", int'(m_tlast), 0);
        check("rst_tuser", int'(m_tuser), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_good", int'(stat_good), 0);
        check("rst_bad", int'(stat_bad), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        exp_good = 0; exp_bad = 0;

        // Table-driven whole frames
        for (int v = 0; v < 9; v++) begin
            clear_mon();
            send_frame(vecs[v].npre, vecs[v].len, vecs[v].er_idx, vecs[v].er_pre, 3);
            exp_good = exp_good + vecs[v].dgood;
            exp_bad  = exp_bad + vecs[v].dbad;
            check($sformatf("v%0d_count", v), out_cnt, vecs[v].exp_n);
            check($sformatf("v%0d_data", v), data_err, 0);
            check($sformatf("v%0d_lastcnt", v), last_cnt, vecs[v].exp_last);
            check($sformatf("v%0d_stray", v), stray, 0);
            if (vecs[v].exp_last != 0) begin
                check($sformatf("v%0d_tuser", v), last_tuser, vecs[v].exp_tuser);
                check($sformatf("v%0d_lastpos", v), last_pos, vecs[v].exp_n);
            end
            check($sformatf("v%0d_good", v), int'(stat_good), exp_good);
            check($sformatf("v%0d_bad", v), int'(stat_bad), exp_bad);
            check($sformatf("v%0d_busy", v), int'(busy), 0);
        end

        // Junk frame then aborted preamble
        clear_mon();
        drive(1'b1, 1'b0, 8'hAA);
        check("junk_busy", int'(busy), 1);
        for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 8'h55);
        drive(1'b0, 1'b0, 8'h00);
        check("junk_busy_off", int'(busy), 0);
        drive(1'b1, 1'b0, 8'h55);
        check("pre_busy", int'(busy), 1);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h12);
        check("abort_busy", int'(busy), 1);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        exp_bad = exp_bad + 2;
        check("junk_bad", int'(stat_bad), exp_bad);
        check("junk_out", out_cnt, 0);
        check("junk_busy_end", int'(busy), 0);

        // Back-to-back with a single idle cycle
        clear_mon();
        send_frame(7, 64, -1, 1'b0, 1);
        send_frame(7, 64, -1, 1'b0, 3);
        exp_good = exp_good + 2;
        check("b2b_out", out_cnt, 128);
        check("b2b_last", last_cnt, 2);
        check("b2b_data", data_err, 0);
        check("b2b_good", int'(stat_good), exp_good);

        // cfg_enable dropped mid-frame: current completes, next dropped
        clear_mon();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 64; i++) begin
            if (i == 5) cfg_enable = 1'b0;
            drive(1'b1, 1'b0, 8'(i));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
        exp_good = exp_good + 1;
        check("cfg_out", out_cnt, 64);
        check("cfg_last", last_cnt, 1);
        check("cfg_tuser", last_tuser, 0);
        check("cfg_good", int'(stat_good), exp_good);
        clear_mon();
        send_frame(7, 64, -1, 1'b0, 3);
        exp_bad = exp_bad + 1;
        check("cfg_drop_out", out_cnt, 0);
        check("cfg_drop_bad", int'(stat_bad), exp_bad);
        cfg_enable = 1'b1;

        // Reset pulse at payload byte 30
        clear_mon();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 8'(i));
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'd30);
        rst_n = 1'b1;
        check("mrst_tvalid", int'(m_tvalid), 0);
        check("mrst_tdata", int'(m_tdata), 0);
        check("mrst_tlast", int'(m_tlast), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_good", int'(stat_good), 0);
        check("mrst_bad", int'(stat_bad), 0);
        for (int i = 31; i < 64; i++) drive(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
        check("mrst_out", out_cnt, 29);
        check("mrst_nolast", last_cnt, 0);
        check("mrst_bad_after", int'(stat_bad), 1);
        check("mrst_good_after", int'(stat_good), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
